// File: rtl/rv_mem_pkg.sv
// Shared encodings for the data-memory responder: load/store types, FSM states
// and the lane-selection helpers used by the responder datapath.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    LoadLw  = 2'b00,
    LoadLb  = 2'b01,
    LoadLbu = 2'b10,
    LoadLh  = 2'b11
  } load_type_e;

  typedef enum logic {
    StoreSw = 1'b0,
    StoreSb = 1'b1
  } store_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } dmem_state_e;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input load_type_e lt,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (lt)
      LoadLb:  load_extract = {{24{b[7]}}, b};
      LoadLbu: load_extract = {24'h000000, b};
      LoadLh:  load_extract = {{16{h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input store_type_e st, input logic [1:0] off);
    store_be = (st == StoreSb) ? (4'b0001 << off) : 4'b1111;
  endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port word SRAM: synchronous 1-cycle read, per-byte write enables.
module sram_1rw_be #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: IDLE/ACCESS/RESP handshake around a byte-enabled SRAM.
// Optional misaligned-access detection is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        load_type,
  input  logic              store_type,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rdata,
  output logic              rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  dmem_state_e state_q, state_d;

  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  load_type_e    lt_q;
  store_type_e   st_q;

  logic          sram_en;
  logic [3:0]    sram_be;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;
  logic          misalign;

  // Bits above the array range never affect the access.
  logic unused_addr;
  assign unused_addr = ^addr[ADDR_W-1:AW+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      lt_q    <= LoadLw;
      st_q    <= StoreSw;
    end else if (state_q == StIdle && req_valid) begin
      addr_q  <= addr[AW+1:0];
      wdata_q <= wdata;
      we_q    <= mem_write;
      lt_q    <= load_type_e'(load_type);
      st_q    <= store_type_e'(store_type);
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    sram_en   = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StAccess;
      end
      StAccess: begin
        sram_en = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  always_comb begin
    if (we_q) begin
      misalign = (st_q == StoreSw) && (addr_q[1:0] != 2'b00);
    end else begin
      misalign = ((lt_q == LoadLw) && (addr_q[1:0] != 2'b00)) ||
                 ((lt_q == LoadLh) && addr_q[0]);
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign sram_be    = (we_q && !misalign) ? store_be(st_q, addr_q[1:0]) : 4'b0000;
  assign sram_wdata = (st_q == StoreSb) ? {4{wdata_q[7:0]}} : wdata_q;

  sram_1rw_be #(
    .DEPTH(DEPTH)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .be   (sram_be),
    .addr (addr_q[AW+1:2]),
    .wdata(sram_wdata),
    .rdata(sram_rdata)
  );

  // SRAM output register holds its value until the next access, so rdata stays stable in RESP.
  assign rdata   = (rsp_valid && !we_q && !misalign) ?
                   load_extract(sram_rdata, lt_q, addr_q[1:0]) : 32'h0;
  assign rsp_err = rsp_valid && misalign;

endmodule
